// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle next-PC controller resolving branch/jump/JR/RTE and exception entry.
// Optional PC_SEQ_STATS_EN adds saturating taken-branch and exception-entry counters.
module pc_sequencer #(
  parameter int MEM_LATENCY = 2,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic [2:0]        op,
  input  logic              cond,
  input  logic              exc,
  input  logic [1:0]        exc_cause,
  output logic              busy,
  output logic              done,
  output logic [2:0]        pc_src,
  output logic              pc_write,
  output logic              epc_write,
  output logic              vec_rd,
  output logic [7:0]        vec_addr,
  output logic [STAT_W-1:0] branch_cnt,
  output logic [STAT_W-1:0] exc_cnt
);
  typedef enum logic [2:0] {IDLE, UPDATE, EXC_EPC, EXC_WAIT, EXC_LOAD} state_t;
  localparam logic [3:0] WAIT_INIT = 4'(MEM_LATENCY > 0 ? MEM_LATENCY - 1 : 0);
  state_t state, state_n;
  logic [2:0] op_q, op_n, src_n;
  logic cond_q, cond_n;
  logic [1:0] cause_q, cause_n, cause_in;
  logic [3:0] wcnt;
  logic pc_write_q, done_q;
  assign cause_in = exc_cause == 2'b11 ? 2'b00 : exc_cause;
  always_comb begin
    state_n = state;
    op_n = op_q;
    cond_n = cond_q;
    cause_n = cause_q;
    case (state)
      IDLE: begin
        if (exc) begin
          state_n = EXC_EPC;
          cause_n = cause_in;
        end else if (req && op <= 3'd4) begin
          state_n = UPDATE;
          op_n = op;
          cond_n = cond;
        end else if (req) begin
          state_n = EXC_EPC;
          cause_n = 2'b00;
        end
      end
      UPDATE: begin
        state_n = exc ? EXC_EPC : IDLE;
        cause_n = exc ? cause_in : cause_q;
      end
      EXC_EPC: state_n = MEM_LATENCY == 0 ? EXC_LOAD : EXC_WAIT;
      EXC_WAIT: state_n = wcnt == 4'd0 ? EXC_LOAD : EXC_WAIT;
      default: state_n = IDLE;
    endcase
    src_n = op_n == 3'd0 ? 3'b001 :
            op_n == 3'd1 ? (cond_n ? 3'b010 : 3'b001) :
            op_n == 3'd2 ? 3'b011 :
            op_n == 3'd3 ? 3'b101 : 3'b100;
  end
  // Outputs are registered from the next state so they are valid for the whole state cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      op_q <= 3'd0;
      cond_q <= 1'b0;
      cause_q <= 2'b00;
      wcnt <= 4'd0;
      busy <= 1'b0;
      done_q <= 1'b0;
      pc_write_q <= 1'b0;
      epc_write <= 1'b0;
      vec_rd <= 1'b0;
      pc_src <= 3'b001;
      vec_addr <= 8'd253;
    end else begin
      state <= state_n;
      op_q <= op_n;
      cond_q <= cond_n;
      cause_q <= cause_n;
      wcnt <= state == EXC_EPC ? WAIT_INIT : (state == EXC_WAIT && wcnt != 4'd0 ? wcnt - 4'd1 : wcnt);
      busy <= state_n != IDLE;
      done_q <= state_n == UPDATE || state_n == EXC_LOAD;
      pc_write_q <= (state_n == UPDATE && !(op_n == 3'd1 && !cond_n)) || state_n == EXC_LOAD;
      epc_write <= state_n == EXC_EPC;
      vec_rd <= state_n == EXC_EPC;
      pc_src <= state_n == UPDATE ? src_n : state_n == EXC_LOAD ? 3'b000 : pc_src;
      vec_addr <= state_n == EXC_EPC ? 8'd253 + 8'(cause_n) : vec_addr;
    end
  end
  // An exception arriving during UPDATE cancels that cycle's PC write.
  assign pc_write = pc_write_q && !(state == UPDATE && exc);
  assign done = done_q && !(state == UPDATE && exc);
`ifdef PC_SEQ_STATS_EN
  logic br_taken;
  assign br_taken = state == UPDATE && pc_write && op_q inside {3'd1, 3'd2, 3'd3};
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      branch_cnt <= '0;
      exc_cnt <= '0;
    end else begin
      branch_cnt <= br_taken && !(&branch_cnt) ? branch_cnt + 1'b1 : branch_cnt;
      exc_cnt <= state == EXC_EPC && !(&exc_cnt) ? exc_cnt + 1'b1 : exc_cnt;
    end
  end
`else
  assign branch_cnt = '0;
  assign exc_cnt = '0;
`endif
endmodule
